inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
Boot-time program loader that produces the 64-bit dual-issue instruction words the core's fetch stage consumes.
- Accepts a byte stream from the UART receiver over a valid/ready handshake.
- Parses a length header, assembles 64-bit instruction words and writes them into instruction memory.
- Verifies a trailing XOR checksum.
- Holds the core in reset until the whole program is loaded.
- Sits between the UART RX block and the instruction BRAM write port / core reset input.

Parameters:
ADDR_W, 10, instruction memory word-address width; DEPTH = 2**ADDR_W 64-bit words.

Ports:
clk  input  1  system clock
rstn  input  1  synchronous active-low reset
rx_data  input  8  received byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts byte; transfer occurs when rx_valid && rx_ready at posedge clk
imem_addr  output  ADDR_W  instruction memory word address
imem_din  output  64  instruction word; bits 63:32 upper slot, 31:0 lower slot
imem_we  output  1  one-cycle write strobe
word_count  output  ADDR_W+1  number of words written so far
load_done  output  1  program loaded and checksum good (sticky)
load_error  output  1  oversize length or bad checksum (sticky)
cpu_rstn  output  1  active-low reset to the core; 0 until load_done

Behaviour:
Reset (rstn=0 at posedge clk):
- state=HDR; byte/word counters 0; checksum accumulator 0.
- imem_we=0, imem_addr=0, imem_din=0, word_count=0.
- load_done=0, load_error=0, cpu_rstn=0; rx_ready=0 during reset.
- Reset mid-operation discards all partial state; memory contents already written are not cleared.

Stream format (all accepted bytes are XORed into the checksum except the checksum byte itself):
- 4 header bytes: N (32-bit word count), little-endian.
- N*8 body bytes: each instruction big-endian; first byte lands in din[63:56].
- 1 checksum byte.

States:
- HDR: rx_ready=1. Shift in 4 bytes.
  - On the 4th accepted byte: if N > DEPTH go to ERR; else if N==0 go to CSUM; else go to BODY.
- BODY: rx_ready=1. Shift each byte into a 64-bit assembly register.
  - On the 8th byte of a word, the next cycle has imem_we=1, imem_addr=word index, imem_din=assembled word.
  - word_count increments in that same cycle.
  - After word N-1 the state goes to CSUM.
  - Write latency: exactly 1 cycle after the final byte handshake.
  - rx_ready stays 1 during the write cycle, so back-to-back bytes are accepted with no bubble.
- CSUM: rx_ready=1. On the accepted byte, compare with the accumulator.
  - Equal: go to DONE.
  - Not equal: go to ERR.
- DONE: rx_ready=0, load_done=1, cpu_rstn=1 from the cycle after entry. Terminal until rstn.
- ERR: rx_ready=0, load_error=1, cpu_rstn stays 0. Terminal until rstn.

Handshake and boundary rules:
- Gaps in rx_valid stall counters; nothing advances without a handshake.
- rx_data is ignored when rx_valid=0.
- imem_we is never asserted outside BODY, and never more than N times.
- N == DEPTH is legal and fills memory; word index wraps nowhere.
- Bytes arriving in DONE/ERR are not accepted; the UART side must drop or hold them.
- load_done and load_error are mutually exclusive.

Decomposition:
Package loader_pkg:
- state enum {HDR, BODY, CSUM, DONE, ERR}
- HDR_BYTES=4, INST_BYTES=8 constants

Sub-module word_assembler:
- 64-bit shift register with byte counter.
- Outputs word_valid pulse and word.
- Reusable for any future 64-bit data-memory preload.

Test Plan:
1. Normal load: bytes 01 00 00 00, 11 22 33 44 55 66 77 88, 89 -> one write at addr 0 of 0x1122334455667788 one cycle after byte 0x88; load_done=1, cpu_rstn=1, word_count=1, rx_ready=0.
2. Bad checksum: same stream with final byte 0x8A -> write still occurs; load_error=1, load_done=0, cpu_rstn stays 0.
3. Empty program: 00 00 00 00, 00 -> no imem_we; load_done=1.
4. Oversize (ADDR_W=2): header 05 00 00 00 -> load_error=1 the cycle after the 4th byte; rx_ready=0; no writes.
5. Throttled input, N=2, rx_valid toggled every other cycle -> writes at addr 0 and 1 with correct words; checksum accepted.
6. rstn pulsed after 5 body bytes, then the full valid stream of test 1 sent -> all state restarts at HDR; the word is written correctly at addr 0; load_done=1.

Source files
------------

// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
//   Shared definitions for the boot-time instruction loader.
//   - state_t    : loader protocol phase
//   - HDR_BYTES  : length header size in bytes (little-endian word count)
//   - INST_BYTES : bytes per 64-bit dual-issue instruction word
// ---------------------------------------------------------------------------
package loader_pkg;

   typedef enum logic [2:0] {
      HDR,
      BODY,
      CSUM,
      DONE,
      ERR
   } state_t;

   localparam int unsigned HDR_BYTES  = 4;
   localparam int unsigned INST_BYTES = 8;

endpackage

// File: rtl/word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
//   Packs a byte stream into 64-bit words, big-endian: the first byte of a
//   word ends up in word[63:56]. A registered one-cycle word_valid pulse
//   follows the cycle in which the eighth byte was taken.
//
//   clk, rstn   : clock, synchronous active-low reset
//   byte_valid  : byte_data is consumed this cycle
//   byte_data   : incoming byte
//   last_byte   : the next consumed byte completes a word
//   word_valid  : one-cycle pulse, word holds a freshly completed value
//   word        : last completed word (held until the next completion)
// ---------------------------------------------------------------------------
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        last_byte,
   output logic        word_valid,
   output logic [63:0] word
);

   logic [2:0]  byte_cnt;
   // Only the first seven bytes of a word need holding; the eighth is
   // concatenated straight from the input when the word is published.
   logic [55:0] shift_reg;

   assign last_byte = (byte_cnt == 3'(INST_BYTES - 1));

   always_ff @(posedge clk) begin
      if (!rstn) begin
         byte_cnt   <= '0;
         shift_reg  <= '0;
         word_valid <= 1'b0;
         word       <= '0;
      end else begin
         word_valid <= 1'b0;
         if (byte_valid) begin
            shift_reg <= {shift_reg[47:0], byte_data};
            if (last_byte) begin
               word       <= {shift_reg, byte_data};
               word_valid <= 1'b1;
               byte_cnt   <= '0;
            end else begin
               byte_cnt <= byte_cnt + 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/inst_loader.sv
// ---------------------------------------------------------------------------
// inst_loader
//   Boot-time program loader. Takes a byte stream from the UART receiver,
//   parses a 4-byte little-endian word count N, writes N big-endian 64-bit
//   instruction words into instruction memory and checks a trailing XOR
//   checksum. The core is held in reset until the program is loaded.
//
//   clk, rstn  : clock, synchronous active-low reset
//   rx_data    : received byte
//   rx_valid   : rx_data valid
//   rx_ready   : byte accepted when rx_valid && rx_ready at posedge clk
//   imem_addr  : instruction memory word address
//   imem_din   : instruction word (63:32 upper slot, 31:0 lower slot)
//   imem_we    : one-cycle write strobe
//   word_count : words written so far
//   load_done  : program loaded with good checksum (sticky)
//   load_error : oversize length or bad checksum (sticky)
//   cpu_rstn   : active-low core reset, released once load_done is set
// ---------------------------------------------------------------------------
module inst_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [63:0]       imem_din,
   output logic              imem_we,
   output logic [ADDR_W:0]   word_count,
   output logic              load_done,
   output logic              load_error,
   output logic              cpu_rstn
);

   localparam logic [32:0] DEPTH = 33'(1) << ADDR_W;

   state_t          state;
   logic [23:0]     hdr_sh;
   logic [1:0]      hdr_cnt;
   logic [7:0]      csum;
   logic [ADDR_W:0] n_words;

   logic            accept;
   logic [31:0]     n_full;
   logic            asm_last;
   logic            asm_valid;
   logic [63:0]     asm_word;

   assign accept = rx_valid && rx_ready;

   // Header arrives LSB first; the fourth byte is the MSB.
   assign n_full = {rx_data, hdr_sh};

   word_assembler u_asm (
      .clk        (clk),
      .rstn       (rstn),
      .byte_valid (accept && (state == BODY)),
      .byte_data  (rx_data),
      .last_byte  (asm_last),
      .word_valid (asm_valid),
      .word       (asm_word)
   );

   // The assembler's pulse and word are already registered and land in the
   // cycle after the eighth byte, which is exactly the write cycle.
   assign imem_we  = asm_valid;
   assign imem_din = asm_word;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= HDR;
         hdr_sh     <= '0;
         hdr_cnt    <= '0;
         csum       <= '0;
         n_words    <= '0;
         imem_addr  <= '0;
         word_count <= '0;
         load_done  <= 1'b0;
         load_error <= 1'b0;
         cpu_rstn   <= 1'b0;
         rx_ready   <= 1'b0;
      end else begin
         unique case (state)
            HDR: begin
               rx_ready <= 1'b1;
               if (accept) begin
                  csum    <= csum ^ rx_data;
                  hdr_sh  <= {rx_data, hdr_sh[23:8]};
                  hdr_cnt <= hdr_cnt + 2'd1;
                  if (hdr_cnt == 2'(HDR_BYTES - 1)) begin
                     if ({1'b0, n_full} > DEPTH) begin
                        state      <= ERR;
                        rx_ready   <= 1'b0;
                        load_error <= 1'b1;
                     end else if (n_full == '0) begin
                        state <= CSUM;
                     end else begin
                        state   <= BODY;
                        n_words <= n_full[ADDR_W:0];
                     end
                  end
               end
            end

            BODY: begin
               if (accept) begin
                  csum <= csum ^ rx_data;
                  if (asm_last) begin
                     // Address and count move together with the assembler's
                     // pulse so all three appear in the write cycle.
                     imem_addr  <= word_count[ADDR_W-1:0];
                     word_count <= word_count + (ADDR_W + 1)'(1);
                     if (word_count + (ADDR_W + 1)'(1) == n_words) begin
                        state <= CSUM;
                     end
                  end
               end
            end

            CSUM: begin
               if (accept) begin
                  rx_ready <= 1'b0;
                  if (rx_data == csum) begin
                     state     <= DONE;
                     load_done <= 1'b1;
                     cpu_rstn  <= 1'b1;
                  end else begin
                     state      <= ERR;
                     load_error <= 1'b1;
                  end
               end
            end

            DONE: rx_ready <= 1'b0;

            ERR: rx_ready <= 1'b0;

            default: begin
               state      <= ERR;
               rx_ready   <= 1'b0;
               load_error <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;

   // Instance A: default ADDR_W=10
   logic [7:0]  rx_data_a;
   logic        rx_valid_a;
   logic        rx_ready_a;
   logic [9:0]  imem_addr_a;
   logic [63:0] imem_din_a;
   logic        imem_we_a;
   logic [10:0] word_count_a;
   logic        load_done_a;
   logic        load_error_a;
   logic        cpu_rstn_a;

   // Instance B: ADDR_W=2 (DEPTH=4) for size boundaries
   logic [7:0]  rx_data_b;
   logic        rx_valid_b;
   logic        rx_ready_b;
   logic [1:0]  imem_addr_b;
   logic [63:0] imem_din_b;
   logic        imem_we_b;
   logic [2:0]  word_count_b;
   logic        load_done_b;
   logic        load_error_b;
   logic        cpu_rstn_b;

   inst_loader #(.ADDR_W(10)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .rx_data    (rx_data_a),
      .rx_valid   (rx_valid_a),
      .rx_ready   (rx_ready_a),
      .imem_addr  (imem_addr_a),
      .imem_din   (imem_din_a),
      .imem_we    (imem_we_a),
      .word_count (word_count_a),
      .load_done  (load_done_a),
      .load_error (load_error_a),
      .cpu_rstn   (cpu_rstn_a)
   );

   inst_loader #(.ADDR_W(2)) dut_s (
      .clk        (clk),
      .rstn       (rstn),
      .rx_data    (rx_data_b),
      .rx_valid   (rx_valid_b),
      .rx_ready   (rx_ready_b),
      .imem_addr  (imem_addr_b),
      .imem_din   (imem_din_b),
      .imem_we    (imem_we_b),
      .word_count (word_count_b),
      .load_done  (load_done_b),
      .load_error (load_error_b),
      .cpu_rstn   (cpu_rstn_b)
   );

   int nchk  = 0;
   int nfail = 0;

   typedef struct packed {
      logic [9:0]  addr;
      logic [63:0] data;
   } wr_t;

   wr_t         exp_a[$];
   wr_t         exp_b[$];
   logic [63:0] prog[$];

   // Scoreboard monitors: every write strobe must match the next expected write
   always @(posedge clk) begin : mon_a
      wr_t e;
      #1;
      if (imem_we_a === 1'b1) begin
         nchk++;
         if (exp_a.size() == 0) begin
            nfail++;
            $display("FAIL write_a_unexpected: got addr %0d data %h, no write expected", imem_addr_a, imem_din_a);
         end else begin
            e = exp_a.pop_front();
            if (imem_addr_a !== e.addr || imem_din_a !== e.data) begin
               nfail++;
               $display("FAIL write_a: got addr %0d data %h, expected addr %0d data %h",
                        imem_addr_a, imem_din_a, e.addr, e.data);
            end
         end
      end
   end

   always @(posedge clk) begin : mon_b
      wr_t e;
      #1;
      if (imem_we_b === 1'b1) begin
         nchk++;
         if (exp_b.size() == 0) begin
            nfail++;
            $display("FAIL write_b_unexpected: got addr %0d data %h, no write expected", imem_addr_b, imem_din_b);
         end else begin
            e = exp_b.pop_front();
            if (10'(imem_addr_b) !== e.addr || imem_din_b !== e.data) begin
               nfail++;
               $display("FAIL write_b: got addr %0d data %h, expected addr %0d data %h",
                        imem_addr_b, imem_din_b, e.addr, e.data);
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one byte and hold it until a handshake edge has passed.
   task automatic send(input bit sel, input logic [7:0] b);
      logic rdy;
      if (sel) begin rx_data_b = b; rx_valid_b = 1'b1; end
      else     begin rx_data_a = b; rx_valid_a = 1'b1; end
      for (int unsigned k = 0; k < 50; k++) begin
         rdy = sel ? rx_ready_b : rx_ready_a;
         @(posedge clk); #1;
         if (rdy === 1'b1) return;
      end
      nchk++;
      nfail++;
      $display("FAIL send_timeout: byte %h not accepted, rx_ready stayed %b, required 1", b, rdy);
   endtask

   task automatic idle(input int unsigned n);
      rx_valid_a = 1'b0;
      rx_valid_b = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      rx_valid_a = 1'b0;
      rx_valid_b = 1'b0;
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   // Full stream: header, body from prog[], checksum (optionally corrupted)
   task automatic load_stream(input bit sel, input logic [31:0] n, input bit bad, input bit thr);
      logic [7:0]  cs;
      logic [7:0]  b;
      logic [63:0] w;
      wr_t         e;
      cs = 8'h00;
      for (int unsigned i = 0; i < 4; i++) begin
         b = n[8*i +: 8];
         cs ^= b;
         send(sel, b);
         if (thr) idle(1);
      end
      for (int unsigned j = 0; j < n; j++) begin
         w = prog[j];
         e.addr = 10'(j);
         e.data = w;
         if (sel) exp_b.push_back(e); else exp_a.push_back(e);
         for (int i = 7; i >= 0; i--) begin
            b = w[8*i +: 8];
            cs ^= b;
            send(sel, b);
            if (i == 0) begin
               nchk++;
               if ((sel ? imem_we_b : imem_we_a) !== 1'b1) begin
                  nfail++;
                  $display("FAIL write_latency: word %0d imem_we=%b one cycle after last byte, required 1",
                           j, sel ? imem_we_b : imem_we_a);
               end
            end
            if (thr) idle(1);
         end
      end
      send(sel, bad ? (cs ^ 8'h03) : cs);
   endtask

   task automatic check_sb_empty(input string name);
      nchk++;
      if (exp_a.size() != 0 || exp_b.size() != 0) begin
         nfail++;
         $display("FAIL %s_pending_writes: a=%0d b=%0d outstanding, required 0", name, exp_a.size(), exp_b.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      nchk++;
      if (imem_we_a !== 1'b0 || imem_addr_a !== 10'd0 || imem_din_a !== 64'd0 || word_count_a !== 11'd0) begin
         nfail++;
         $display("FAIL reset_mem: we=%b addr=%0d din=%h cnt=%0d, required 0 0 0 0",
                  imem_we_a, imem_addr_a, imem_din_a, word_count_a);
      end
      nchk++;
      if (load_done_a !== 1'b0 || load_error_a !== 1'b0 || cpu_rstn_a !== 1'b0 || rx_ready_a !== 1'b0) begin
         nfail++;
         $display("FAIL reset_status: done=%b err=%b cpu_rstn=%b ready=%b, required 0 0 0 0",
                  load_done_a, load_error_a, cpu_rstn_a, rx_ready_a);
      end
      idle(1);
      nchk++;
      if (rx_ready_a !== 1'b1 || rx_ready_b !== 1'b1) begin
         nfail++;
         $display("FAIL reset_ready_hdr: ready a=%b b=%b, required 1 1", rx_ready_a, rx_ready_b);
      end
   endtask

   task automatic test_normal();
      do_reset();
      prog = '{64'h1122334455667788};
      load_stream(1'b0, 32'd1, 1'b0, 1'b0);
      nchk++;
      if (load_done_a !== 1'b1 || cpu_rstn_a !== 1'b1 || load_error_a !== 1'b0 ||
          rx_ready_a !== 1'b0 || word_count_a !== 11'd1) begin
         nfail++;
         $display("FAIL normal_status: done=%b cpu_rstn=%b err=%b ready=%b cnt=%0d, required 1 1 0 0 1",
                  load_done_a, cpu_rstn_a, load_error_a, rx_ready_a, word_count_a);
      end
      // Bytes after DONE must not be taken
      rx_data_a  = 8'h5A;
      rx_valid_a = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      nchk++;
      if (rx_ready_a !== 1'b0 || word_count_a !== 11'd1 || load_done_a !== 1'b1) begin
         nfail++;
         $display("FAIL done_terminal: ready=%b cnt=%0d done=%b, required 0 1 1", rx_ready_a, word_count_a, load_done_a);
      end
      idle(1);
      check_sb_empty("normal");
   endtask

   task automatic test_bad_csum();
      do_reset();
      prog = '{64'h1122334455667788};
      load_stream(1'b0, 32'd1, 1'b1, 1'b0);
      nchk++;
      if (load_error_a !== 1'b1 || load_done_a !== 1'b0 || cpu_rstn_a !== 1'b0 ||
          rx_ready_a !== 1'b0 || word_count_a !== 11'd1) begin
         nfail++;
         $display("FAIL bad_csum_status: err=%b done=%b cpu_rstn=%b ready=%b cnt=%0d, required 1 0 0 0 1",
                  load_error_a, load_done_a, cpu_rstn_a, rx_ready_a, word_count_a);
      end
      idle(3);
      check_sb_empty("bad_csum");
   endtask

   task automatic test_empty();
      do_reset();
      prog = {};
      load_stream(1'b0, 32'd0, 1'b0, 1'b0);
      nchk++;
      if (load_done_a !== 1'b1 || load_error_a !== 1'b0 || word_count_a !== 11'd0 || cpu_rstn_a !== 1'b1) begin
         nfail++;
         $display("FAIL empty_status: done=%b err=%b cnt=%0d cpu_rstn=%b, required 1 0 0 1",
                  load_done_a, load_error_a, word_count_a, cpu_rstn_a);
      end
      idle(3);
      check_sb_empty("empty");
   endtask

   task automatic test_oversize();
      do_reset();
      send(1'b1, 8'h05);
      send(1'b1, 8'h00);
      send(1'b1, 8'h00);
      send(1'b1, 8'h00);
      nchk++;
      if (load_error_b !== 1'b1 || rx_ready_b !== 1'b0 || load_done_b !== 1'b0 || cpu_rstn_b !== 1'b0) begin
         nfail++;
         $display("FAIL oversize_status: err=%b ready=%b done=%b cpu_rstn=%b, required 1 0 0 0",
                  load_error_b, rx_ready_b, load_done_b, cpu_rstn_b);
      end
      rx_data_b  = 8'hAA;
      rx_valid_b = 1'b1;
      repeat (10) begin @(posedge clk); #1; end
      nchk++;
      if (word_count_b !== 3'd0 || rx_ready_b !== 1'b0 || load_error_b !== 1'b1) begin
         nfail++;
         $display("FAIL oversize_terminal: cnt=%0d ready=%b err=%b, required 0 0 1", word_count_b, rx_ready_b, load_error_b);
      end
      idle(1);
      check_sb_empty("oversize");
   endtask

   task automatic test_full_depth();
      do_reset();
      prog = {};
      for (int unsigned i = 0; i < 4; i++) prog.push_back({$urandom(), $urandom()});
      load_stream(1'b1, 32'd4, 1'b0, 1'b0);
      nchk++;
      if (load_done_b !== 1'b1 || load_error_b !== 1'b0 || word_count_b !== 3'd4 || cpu_rstn_b !== 1'b1) begin
         nfail++;
         $display("FAIL full_depth_status: done=%b err=%b cnt=%0d cpu_rstn=%b, required 1 0 4 1",
                  load_done_b, load_error_b, word_count_b, cpu_rstn_b);
      end
      idle(2);
      check_sb_empty("full_depth");
   endtask

   task automatic test_throttled();
      do_reset();
      prog = '{64'hDEADBEEF_0BADF00D, 64'h0123456789ABCDEF};
      load_stream(1'b0, 32'd2, 1'b0, 1'b1);
      nchk++;
      if (load_done_a !== 1'b1 || load_error_a !== 1'b0 || word_count_a !== 11'd2) begin
         nfail++;
         $display("FAIL throttled_status: done=%b err=%b cnt=%0d, required 1 0 2",
                  load_done_a, load_error_a, word_count_a);
      end
      idle(2);
      check_sb_empty("throttled");
   endtask

   task automatic test_reset_midstream();
      do_reset();
      send(1'b0, 8'h01);
      send(1'b0, 8'h00);
      send(1'b0, 8'h00);
      send(1'b0, 8'h00);
      send(1'b0, 8'hF1);
      send(1'b0, 8'hF2);
      send(1'b0, 8'hF3);
      send(1'b0, 8'hF4);
      send(1'b0, 8'hF5);
      do_reset();
      nchk++;
      if (word_count_a !== 11'd0 || load_done_a !== 1'b0 || load_error_a !== 1'b0) begin
         nfail++;
         $display("FAIL midreset_cleared: cnt=%0d done=%b err=%b, required 0 0 0", word_count_a, load_done_a, load_error_a);
      end
      prog = '{64'h1122334455667788};
      load_stream(1'b0, 32'd1, 1'b0, 1'b0);
      nchk++;
      if (load_done_a !== 1'b1 || load_error_a !== 1'b0 || word_count_a !== 11'd1) begin
         nfail++;
         $display("FAIL midreset_reload: done=%b err=%b cnt=%0d, required 1 0 1", load_done_a, load_error_a, word_count_a);
      end
      idle(2);
      check_sb_empty("midreset");
   endtask

   initial begin
      rstn       = 1'b0;
      rx_data_a  = 8'h00;
      rx_valid_a = 1'b0;
      rx_data_b  = 8'h00;
      rx_valid_b = 1'b0;
      test_reset();
      test_normal();
      test_bad_csum();
      test_empty();
      test_oversize();
      test_full_depth();
      test_throttled();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
